iic_multi_cfg_ctl: RTL and testbench
====================================

Name: iic_multi_cfg_ctl

Overview:
Parametrised N-channel I2C register-init sequencer. It walks one init table per channel and drives a single shared iic_dri-style command interface, with a bus_sel output for the external SCL/SDA mux. It adds readback verification with bounded retry, table-coded delay entries, a busy timeout, restart on demand, and per-channel done/error flags. It sits between the HDMI rx/tx chip table ROMs and the I2C driver, and its done flags gate video start-up.

Parameters:
CH_NUM, 2, number of channels/tables (1..8); CH_W = max(1, clog2(CH_NUM))
ADDR_W, 16, register address width
DATA_W, 8, register data width
TBL_AW, 8, table index width
PWRUP_CYC, 10000, wait after start before first transaction (1 ms at 10 MHz)
VERIFY, 1, 1 = read back every write and compare
MAX_RETRY, 3, extra write attempts after a readback mismatch
TIMEOUT_CYC, 65535, cycles allowed per driver transaction
AUTO_START, 1, 1 = behave as if start was seen at reset release

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; (re)starts init of all channels
tbl_len  in  CH_NUM*TBL_AW  packed entry count per channel (ch0 in LSBs)
tbl_ch  out  CH_W  table channel select
tbl_idx  out  TBL_AW  table entry index
tbl_entry  in  8+ADDR_W+DATA_W  {dev_id, reg_addr, reg_data}; valid 1 cycle after tbl_ch/tbl_idx
iic_trig  out  1  one-cycle transaction pulse to the driver
w_r  out  1  1 = write, 0 = read
device_id  out  8  I2C device address
addr  out  ADDR_W  register address
data_in  out  DATA_W  write data
busy  in  1  driver busy
data_out  in  DATA_W  driver read data
bus_sel  out  CH_W  channel currently owning the I2C bus
active  out  1  sequencer running
init_over  out  CH_NUM  per-channel done, sticky
cfg_err  out  CH_NUM  per-channel error (mismatch after retries, or timeout), sticky

Behaviour:
- Reset: every output is 0. Reset acts asynchronously at any point, aborting any transaction; no trig is issued in the cycle reset deasserts.
- States: IDLE, PWRUP, FETCH, FETCH_W, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DLY, NEXT_CH, DONE.
- IDLE -> PWRUP on start (or on the first cycle after reset release if AUTO_START=1). Entering PWRUP clears init_over, cfg_err, tbl_ch and tbl_idx, and sets active=1.
- PWRUP: count PWRUP_CYC cycles, then go to FETCH for channel 0.
- FETCH: if tbl_idx == tbl_len[ch], set init_over[ch] and go to NEXT_CH (len 0 gives an immediate done with no trig). Otherwise go to FETCH_W, which spends 1 cycle latching tbl_entry.
- Entry with dev_id == 8'hFF: delay entry of reg_data*1024 cycles in DLY, with no bus traffic. reg_data 0 gives a 0-cycle delay. Then tbl_idx+1 and back to FETCH.
- WR_REQ: wait for busy=0, then drive device_id/addr/data_in with w_r=1 and pulse iic_trig for exactly 1 cycle. Outputs hold until the transaction ends.
- WR_WAIT / RD_WAIT: wait for busy to rise, then fall; the falling edge is transaction end.
- Timeout: TIMEOUT_CYC counted from trig without completion sets cfg_err[ch], abandons the entry (tbl_idx+1), and goes to FETCH.
- After a write: VERIFY=0 goes to the next entry. VERIFY=1 goes to RD_REQ, the same address with w_r=0.
- RD_WAIT captures data_out in the busy-falling cycle. CHECK compares it with reg_data.
  - Match: reset the retry count, tbl_idx+1.
  - Mismatch with retry count < MAX_RETRY: increment the count and go back to WR_REQ.
  - Otherwise: set cfg_err[ch] and continue with the next entry.
- NEXT_CH: after ch == CH_NUM-1 go to DONE; else increment tbl_ch/bus_sel, clear tbl_idx, go to FETCH.
- bus_sel changes only in NEXT_CH while busy=0.
- DONE: active=0, flags hold. start -> PWRUP (full restart). start while active=1 is ignored.
- Index arithmetic is TBL_AW unsigned; tbl_len max 2^TBL_AW-1, so no wrap. The retry counter saturates at MAX_RETRY.
- busy high at trig time: the sequencer waits; it never pulses trig while busy=1.

Test Plan:
- CH_NUM=2, VERIFY=0, len={2,3}, driver model 20-cycle busy -> exactly 5 write trigs in table order; bus_sel 0 for the first 2, 1 for the next 3; init_over 2'b01 then 2'b11; active falls; cfg_err=0.
- VERIFY=1, model returns written data -> alternating w_r 1/0 trigs on the same addr (e.g. 16'h0012/8'h5A); cfg_err=0.
- Model returns 8'h00 for addr 16'h00A0 with MAX_RETRY=3 -> 4 writes plus 4 reads to 16'h00A0; cfg_err[0]=1; the following entry still written; init_over[0]=1.
- Delay entry {8'hFF,x,8'd3} -> no trig for at least 3072 cycles, then the next entry proceeds; len={0,1} -> init_over[0] set with no trig.
- busy stuck at 0 after trig -> cfg_err set TIMEOUT_CYC cycles after trig, next entry issued.
- rst asserted mid-WR_WAIT -> all outputs 0 in the same cycle. After release with AUTO_START=1, PWRUP_CYC passes, then the first trig re-issues entry 0. start during active is ignored; start in DONE clears the flags and reruns.

Source files
------------

// File: rtl/iic_multi_cfg_ctl_if.sv
// Command/response bundle between the init sequencer and an iic_dri-style I2C driver,
// plus the channel select that steers the external SCL/SDA mux.
interface iic_multi_cfg_ctl_if #(
    parameter int CH_NUM = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic              iic_trig;
    logic              w_r;
    logic [7:0]        device_id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic [CH_W-1:0]   bus_sel;

    modport master (
        output iic_trig, w_r, device_id, addr, data_in, bus_sel,
        input  busy, data_out
    );

    modport slave (
        input  iic_trig, w_r, device_id, addr, data_in, bus_sel,
        output busy, data_out
    );
endinterface

// File: rtl/iic_multi_cfg_ctl.sv
// N-channel I2C register-init sequencer: walks one table per channel through a shared
// driver, with readback verify/retry, coded delay entries, busy timeout and done/error flags.
module iic_multi_cfg_ctl #(
    parameter int CH_NUM      = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int TBL_AW      = 8,
    parameter int PWRUP_CYC   = 10000,
    parameter int VERIFY      = 1,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 65535,
    parameter int AUTO_START  = 1,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [CH_NUM*TBL_AW-1:0]     i_tbl_len,
    output logic [CH_W-1:0]              o_tbl_ch,
    output logic [TBL_AW-1:0]            o_tbl_idx,
    input  logic [8+ADDR_W+DATA_W-1:0]   i_tbl_entry,
    output logic                         o_active,
    output logic [CH_NUM-1:0]            o_init_over,
    output logic [CH_NUM-1:0]            o_cfg_err,
    iic_multi_cfg_ctl_if.master          bus
);
    localparam int          RTRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [31:0] LP_PWRUP   = 32'(PWRUP_CYC);
    localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYC);
    localparam logic [CH_W-1:0]   LP_LAST_CH = CH_W'(CH_NUM - 1);
    localparam logic [RTRY_W-1:0] LP_RETRY   = RTRY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PWRUP, ST_FETCH, ST_FETCH_W, ST_WR_REQ, ST_WR_WAIT,
        ST_RD_REQ, ST_RD_WAIT, ST_CHECK, ST_DLY, ST_NEXT_CH, ST_DONE
    } state_t;

    state_t              r_state, w_state_next;
    logic [CH_W-1:0]     r_ch, w_ch_next;
    logic [TBL_AW-1:0]   r_idx, w_idx_next;
    logic [31:0]         r_cnt, w_cnt_next;
    logic [RTRY_W-1:0]   r_retry, w_retry_next;
    logic [7:0]          r_dev, w_dev_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [DATA_W-1:0]   r_wdata, w_wdata_next;
    logic [DATA_W-1:0]   r_rdata, w_rdata_next;
    logic                r_trig, w_trig_next;
    logic                r_wr, w_wr_next;
    logic                r_seen, w_seen_next;
    logic                r_active, w_active_next;
    logic [CH_NUM-1:0]   r_init, w_init_next;
    logic [CH_NUM-1:0]   r_err, w_err_next;
    logic                r_auto, w_auto_next;

    logic [TBL_AW-1:0]   w_len [CH_NUM];
    logic [TBL_AW-1:0]   w_idx_inc;
    logic [7:0]          w_ent_dev;
    logic [ADDR_W-1:0]   w_ent_addr;
    logic [DATA_W-1:0]   w_ent_data;
    logic [31:0]         w_dly_lim;

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_len
            assign w_len[gi] = i_tbl_len[gi*TBL_AW +: TBL_AW];
        end
    endgenerate

    assign w_idx_inc  = r_idx + TBL_AW'(1);
    assign w_ent_dev  = i_tbl_entry[8+ADDR_W+DATA_W-1 -: 8];
    assign w_ent_addr = i_tbl_entry[ADDR_W+DATA_W-1 -: ADDR_W];
    assign w_ent_data = i_tbl_entry[DATA_W-1:0];
    // Delay entries hold a count of 1024-cycle units in the data field.
    assign w_dly_lim  = 32'({r_wdata, 10'b0});

    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_retry_next = r_retry;
        w_dev_next   = r_dev;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_rdata_next = r_rdata;
        w_trig_next  = 1'b0;
        w_wr_next    = r_wr;
        w_seen_next  = r_seen;
        w_active_next = r_active;
        w_init_next  = r_init;
        w_err_next   = r_err;
        w_auto_next  = r_auto;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_active_next = 1'b0;
                if (i_start || (r_state == ST_IDLE && r_auto)) begin
                    w_state_next  = ST_PWRUP;
                    w_ch_next     = '0;
                    w_idx_next    = '0;
                    w_cnt_next    = '0;
                    w_retry_next  = '0;
                    w_init_next   = '0;
                    w_err_next    = '0;
                    w_active_next = 1'b1;
                    w_auto_next   = 1'b0;
                end
            end
            ST_PWRUP: begin
                if (r_cnt + 32'd1 >= LP_PWRUP) begin
                    w_state_next = ST_FETCH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            ST_FETCH: begin
                if (r_idx == w_len[r_ch]) begin
                    w_init_next[r_ch] = 1'b1;
                    w_state_next      = ST_NEXT_CH;
                end else begin
                    w_state_next = ST_FETCH_W;
                end
            end
            ST_FETCH_W: begin
                w_dev_next   = w_ent_dev;
                w_addr_next  = w_ent_addr;
                w_wdata_next = w_ent_data;
                w_retry_next = '0;
                w_cnt_next   = '0;
                w_state_next = (w_ent_dev == 8'hFF) ? ST_DLY : ST_WR_REQ;
            end
            ST_DLY: begin
                if (r_cnt >= w_dly_lim) begin
                    w_idx_next   = w_idx_inc;
                    w_state_next = ST_FETCH;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                if (!bus.busy) begin
                    w_trig_next  = 1'b1;
                    w_wr_next    = (r_state == ST_WR_REQ);
                    w_cnt_next   = '0;
                    w_seen_next  = 1'b0;
                    w_state_next = (r_state == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
                end
            end
            ST_WR_WAIT, ST_RD_WAIT: begin
                if (bus.busy) begin
                    w_seen_next = 1'b1;
                end
                // Transaction ends on the falling edge of busy after it was seen high.
                if (r_seen && !bus.busy) begin
                    if (r_state == ST_RD_WAIT) begin
                        w_rdata_next = bus.data_out;
                        w_state_next = ST_CHECK;
                    end else if (VERIFY != 0) begin
                        w_state_next = ST_RD_REQ;
                    end else begin
                        w_idx_next   = w_idx_inc;
                        w_state_next = ST_FETCH;
                    end
                end else if (r_cnt + 32'd1 >= LP_TIMEOUT) begin
                    w_err_next[r_ch] = 1'b1;
                    w_idx_next       = w_idx_inc;
                    w_state_next     = ST_FETCH;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            ST_CHECK: begin
                if (r_rdata == r_wdata) begin
                    w_retry_next = '0;
                    w_idx_next   = w_idx_inc;
                    w_state_next = ST_FETCH;
                end else if (r_retry < LP_RETRY) begin
                    w_retry_next = r_retry + RTRY_W'(1);
                    w_state_next = ST_WR_REQ;
                end else begin
                    w_err_next[r_ch] = 1'b1;
                    w_retry_next     = '0;
                    w_idx_next       = w_idx_inc;
                    w_state_next     = ST_FETCH;
                end
            end
            ST_NEXT_CH: begin
                // The bus mux only moves while the driver is idle.
                if (!bus.busy) begin
                    if (r_ch == LP_LAST_CH) begin
                        w_state_next  = ST_DONE;
                        w_active_next = 1'b0;
                    end else begin
                        w_ch_next    = r_ch + CH_W'(1);
                        w_idx_next   = '0;
                        w_state_next = ST_FETCH;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ch     <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_retry  <= '0;
            r_dev    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_trig   <= 1'b0;
            r_wr     <= 1'b0;
            r_seen   <= 1'b0;
            r_active <= 1'b0;
            r_init   <= '0;
            r_err    <= '0;
            r_auto   <= (AUTO_START != 0);
        end else begin
            r_state  <= w_state_next;
            r_ch     <= w_ch_next;
            r_idx    <= w_idx_next;
            r_cnt    <= w_cnt_next;
            r_retry  <= w_retry_next;
            r_dev    <= w_dev_next;
            r_addr   <= w_addr_next;
            r_wdata  <= w_wdata_next;
            r_rdata  <= w_rdata_next;
            r_trig   <= w_trig_next;
            r_wr     <= w_wr_next;
            r_seen   <= w_seen_next;
            r_active <= w_active_next;
            r_init   <= w_init_next;
            r_err    <= w_err_next;
            r_auto   <= w_auto_next;
        end
    end

    assign o_tbl_ch      = r_ch;
    assign o_tbl_idx     = r_idx;
    assign o_active      = r_active;
    assign o_init_over   = r_init;
    assign o_cfg_err     = r_err;
    assign bus.iic_trig  = r_trig;
    assign bus.w_r       = r_wr;
    assign bus.device_id = r_dev;
    assign bus.addr      = r_addr;
    assign bus.data_in   = r_wdata;
    assign bus.bus_sel   = r_ch;
endmodule

// File: tb/tb_iic_multi_cfg_ctl.sv
// Bench for iic_multi_cfg_ctl: table ROM + echoing I2C driver model, scoreboard of expected
// transactions built from a scenario table, plus timeout and reset/restart sequences.
module tb_iic_multi_cfg_ctl;
    localparam int TB_PWRUP = 50;
    localparam int TB_TO    = 300;
    localparam int TB_RETRY = 3;
    localparam int BUSY_CYC = 20;

    typedef struct packed {
        logic [7:0]  dev;
        logic [15:0] addr;
        logic [7:0]  data;
    } ent_t;

    typedef struct {
        int          first;
        int          len0;
        int          len1;
        logic [15:0] bad;
        logic [1:0]  exp_init;
        logic [1:0]  exp_err;
    } scn_t;

    typedef struct {
        logic        wr;
        logic [7:0]  dev;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        sel;
        logic [1:0]  init;
        logic [1:0]  err;
        int          min_gap;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] tbl_len = '0;
    logic [0:0]  tbl_ch;
    logic [7:0]  tbl_idx;
    logic [31:0] tbl_entry;
    logic        active;
    logic [1:0]  init_over;
    logic [1:0]  cfg_err;

    always #5 clk = ~clk;

    iic_multi_cfg_ctl_if #(.CH_NUM(2), .ADDR_W(16), .DATA_W(8)) dif();

    iic_multi_cfg_ctl #(
        .CH_NUM(2), .ADDR_W(16), .DATA_W(8), .TBL_AW(8), .PWRUP_CYC(TB_PWRUP),
        .VERIFY(1), .MAX_RETRY(TB_RETRY), .TIMEOUT_CYC(TB_TO), .AUTO_START(1)
    ) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_tbl_len(tbl_len),
        .o_tbl_ch(tbl_ch), .o_tbl_idx(tbl_idx), .i_tbl_entry(tbl_entry),
        .o_active(active), .o_init_over(init_over), .o_cfg_err(cfg_err),
        .bus(dif.master)
    );

    ent_t rom0 [0:7];
    ent_t rom1 [0:7];
    always @(posedge clk)
        tbl_entry <= (tbl_ch == 1'b1) ? rom1[tbl_idx[2:0]] : rom0[tbl_idx[2:0]];

    // Driver model: busy for BUSY_CYC cycles after a trig; reads echo the written data
    // except at bad_addr, which reads back 0. stuck=1 ignores trigs entirely.
    logic        stuck = 1'b0;
    logic [15:0] bad_addr = 16'hFFFF;
    int          bcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dif.busy     <= 1'b0;
            dif.data_out <= '0;
            bcnt         <= 0;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) dif.busy <= 1'b0;
        end else if (dif.iic_trig && !stuck) begin
            dif.busy     <= 1'b1;
            bcnt         <= BUSY_CYC;
            dif.data_out <= (dif.addr == bad_addr) ? 8'h00 : dif.data_in;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   failures = 0;
    int   trig_cnt = 0;
    int   last_trig = 0;
    txn_t exp_q[$];
    ent_t ents [0:11];
    scn_t scns [0:3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_trig();
        txn_t e;
        int   gap;
        logic ok;
        gap       = cyc - last_trig;
        last_trig = cyc;
        trig_cnt++;
        $display("txn %0d: w_r=%b dev=%h addr=%h data=%h sel=%0d init=%b err=%b gap=%0d",
                 trig_cnt, dif.w_r, dif.device_id, dif.addr, dif.data_in, dif.bus_sel,
                 init_over, cfg_err, gap);
        chk("trig_while_busy", 64'(dif.busy), 64'd0);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_trig: got w_r=%b addr=%h, required no transaction",
                     dif.w_r, dif.addr);
            return;
        end
        e  = exp_q.pop_front();
        ok = (dif.w_r === e.wr) && (dif.device_id === e.dev) && (dif.addr === e.addr) &&
             (!e.wr || dif.data_in === e.data) && (dif.bus_sel === e.sel) &&
             (init_over === e.init) && (cfg_err === e.err) && (gap >= e.min_gap);
        if (!ok) begin
            failures++;
            $display("FAIL txn: got w_r=%b dev=%h addr=%h data=%h sel=%0d init=%b err=%b gap=%0d required w_r=%b dev=%h addr=%h data=%h sel=%0d init=%b err=%b gap>=%0d",
                     dif.w_r, dif.device_id, dif.addr, dif.data_in, dif.bus_sel, init_over,
                     cfg_err, gap, e.wr, e.dev, e.addr, e.data, e.sel, e.init, e.err, e.min_gap);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst && dif.iic_trig) check_trig();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_active(input logic lvl, input int lim, input string name);
        int n = 0;
        while (active !== lvl && n < lim) begin
            tick();
            n++;
        end
        chk(name, 64'(active), 64'(lvl));
    endtask

    task automatic wait_trig(input int lim, input string name);
        int c0 = trig_cnt;
        int n = 0;
        while (trig_cnt == c0 && n < lim) begin
            tick();
            n++;
        end
        chk(name, 64'(trig_cnt != c0), 64'd1);
    endtask

    task automatic load_scn(input int s);
        for (int i = 0; i < 8; i++) begin
            rom0[i] = '0;
            rom1[i] = '0;
        end
        for (int i = 0; i < scns[s].len0; i++) rom0[i] = ents[scns[s].first + i];
        for (int i = 0; i < scns[s].len1; i++) rom1[i] = ents[scns[s].first + scns[s].len0 + i];
        tbl_len  = {8'(scns[s].len1), 8'(scns[s].len0)};
        bad_addr = scns[s].bad;
    endtask

    // Reference order: each normal entry is a write then a readback; a bad-readback
    // entry repeats that TB_RETRY+1 times before its channel error flag is set.
    task automatic push_model(input int s);
        logic [1:0] err = 2'b00;
        int         gap = 0;
        int         nw;
        logic       ch;
        logic [1:0] init;
        ent_t       e;
        for (int k = 0; k < scns[s].len0 + scns[s].len1; k++) begin
            ch   = (k >= scns[s].len0);
            init = ch ? 2'b01 : 2'b00;
            e    = ents[scns[s].first + k];
            if (e.dev == 8'hFF) begin
                gap += int'(e.data) * 1024;
                continue;
            end
            nw = (e.addr == scns[s].bad) ? TB_RETRY + 1 : 1;
            for (int j = 0; j < nw; j++) begin
                exp_q.push_back('{1'b1, e.dev, e.addr, e.data, ch, init, err, gap});
                gap = 0;
                exp_q.push_back('{1'b0, e.dev, e.addr, e.data, ch, init, err, 0});
            end
            if (e.addr == scns[s].bad) err[ch] = 1'b1;
        end
    endtask

    task automatic finish_run(input int s, input string name);
        wait_active(1'b0, 20000, {name, "_active_fall"});
        chk({name, "_init_over"}, 64'(init_over), 64'(scns[s].exp_init));
        chk({name, "_cfg_err"}, 64'(cfg_err), 64'(scns[s].exp_err));
        chk({name, "_all_txns_seen"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int t0;
        int rc;

        ents[0]  = '{8'h50, 16'h0012, 8'h5A};
        ents[1]  = '{8'h50, 16'h0013, 8'hA5};
        ents[2]  = '{8'h60, 16'h0100, 8'h11};
        ents[3]  = '{8'h60, 16'h0101, 8'h22};
        ents[4]  = '{8'h60, 16'h0102, 8'h33};
        ents[5]  = '{8'h50, 16'h00A0, 8'h77};
        ents[6]  = '{8'h50, 16'h00A1, 8'h88};
        ents[7]  = '{8'hFF, 16'h0000, 8'h03};
        ents[8]  = '{8'h60, 16'h0200, 8'h44};
        ents[9]  = '{8'h60, 16'h0300, 8'h55};
        ents[10] = '{8'h50, 16'h0400, 8'h01};
        ents[11] = '{8'h50, 16'h0401, 8'h02};
        scns[0]  = '{0,  2, 3, 16'hFFFF, 2'b11, 2'b00};
        scns[1]  = '{5,  2, 2, 16'h00A0, 2'b11, 2'b01};
        scns[2]  = '{9,  0, 1, 16'hFFFF, 2'b11, 2'b00};
        scns[3]  = '{10, 2, 0, 16'hFFFF, 2'b11, 2'b01};

        load_scn(0);
        tick();
        tick();
        chk("reset_outputs", 64'({dif.iic_trig, dif.w_r, dif.device_id, dif.addr, dif.data_in,
                                  dif.bus_sel, active, init_over, cfg_err, tbl_ch, tbl_idx}), 64'd0);

        // Table-driven runs: scenario 0 starts on reset release, the rest on start in DONE.
        for (int s = 0; s < 3; s++) begin
            load_scn(s);
            exp_q.delete();
            push_model(s);
            if (s == 0) rst = 1'b0;
            else        pulse_start();
            wait_active(1'b1, 5, $sformatf("scn%0d_active_rise", s));
            finish_run(s, $sformatf("scn%0d", s));
        end

        // Driver never answers: each write times out TIMEOUT_CYC after its trig.
        load_scn(3);
        stuck = 1'b1;
        exp_q.delete();
        exp_q.push_back('{1'b1, 8'h50, 16'h0400, 8'h01, 1'b0, 2'b00, 2'b00, 0});
        exp_q.push_back('{1'b1, 8'h50, 16'h0401, 8'h02, 1'b0, 2'b00, 2'b01, 0});
        pulse_start();
        wait_trig(2000, "timeout_first_trig");
        t0 = last_trig;
        begin
            int n = 0;
            while (cfg_err[0] !== 1'b1 && n < 2 * TB_TO) begin
                tick();
                n++;
            end
        end
        chk("timeout_delay", 64'(cyc - t0), 64'(TB_TO));
        finish_run(3, "timeout");
        stuck = 1'b0;

        // Asynchronous reset in the middle of a write, then auto restart from entry 0.
        load_scn(0);
        exp_q.delete();
        push_model(0);
        pulse_start();
        wait_trig(2000, "rst_first_trig");
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 64'({dif.iic_trig, dif.w_r, dif.device_id, dif.addr,
                                          dif.data_in, dif.bus_sel, active, init_over, cfg_err,
                                          tbl_ch, tbl_idx}), 64'd0);
        tick();
        exp_q.delete();
        push_model(0);
        rst = 1'b0;
        rc  = cyc;
        wait_trig(TB_PWRUP + 100, "restart_first_trig");
        chk("restart_pwrup_wait", 64'((last_trig - rc >= TB_PWRUP) && (last_trig - rc <= TB_PWRUP + 8)), 64'd1);
        repeat (60) tick();
        chk("active_before_ignored_start", 64'(active), 64'd1);
        pulse_start();
        finish_run(0, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
